// File: rtl/digitalclock_timekeeper.sv
// Time-of-day core: 1 Hz prescaler, BCD hh:mm:ss counters, set-mode increment path.
// Define DIGITALCLOCK_12H_EN for a 12-hour display with a registered pm output.
module digitalclock_timekeeper #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_hours,
  input  logic       set_minutes,
  input  logic       inc,
  output logic [1:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       colon,
  output logic       tick
`ifdef DIGITALCLOCK_12H_EN
  ,
  output logic       pm
`endif
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {RUN, SET_H, SET_M} mode_t;

  mode_t         mode;
  logic [CW-1:0] cnt;
  logic [5:0]    hr_q, hr_n;
  logic [6:0]    min_q, min_n;
  logic [6:0]    sec_q, sec_n;
  logic          inc_s1, inc_s2, inc_d;
  logic          pulse;

  // Minutes/seconds style counter: {tens[2:0], ones[3:0]} wrapping 59 -> 00.
  function automatic logic [6:0] inc60(input logic [6:0] v);
    logic [6:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[6:4] = (v[6:4] == 3'd5) ? 3'd0 : v[6:4] + 3'd1;
    end else begin
      r = {v[6:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [5:0] inc24(input logic [5:0] v);
    logic [5:0] r;
    if (v == 6'h23)             r = 6'h00;
    else if (v[3:0] == 4'd9)    r = {v[5:4] + 2'd1, 4'd0};
    else                        r = {v[5:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_comb begin
    if (set_hours)        mode = SET_H;
    else if (set_minutes) mode = SET_M;
    else                  mode = RUN;
  end

  assign pulse = inc_s2 & ~inc_d;

  // Next time-of-day; tick and the inc pulse act on the mode decoded this cycle.
  always_comb begin
    hr_n  = hr_q;
    min_n = min_q;
    sec_n = sec_q;
    case (mode)
      RUN: begin
        if (tick) begin
          sec_n = inc60(sec_q);
          if (sec_q == 7'h59) begin
            min_n = inc60(min_q);
            if (min_q == 7'h59) hr_n = inc24(hr_q);
          end
        end
      end
      SET_H: begin
        sec_n = 7'h00;
        if (pulse) hr_n = inc24(hr_q);
      end
      SET_M: begin
        sec_n = 7'h00;
        if (pulse) min_n = inc60(min_q);
      end
      default: sec_n = 7'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      tick   <= 1'b0;
      colon  <= 1'b0;
      hr_q   <= '0;
      min_q  <= '0;
      sec_q  <= '0;
      inc_s1 <= 1'b0;
      inc_s2 <= 1'b0;
      inc_d  <= 1'b0;
    end else begin
      inc_s1 <= inc;
      inc_s2 <= inc_s1;
      inc_d  <= inc_s2;
      hr_q   <= hr_n;
      min_q  <= min_n;
      sec_q  <= sec_n;
      if (mode != RUN) begin
        cnt   <= '0;
        tick  <= 1'b0;
        colon <= 1'b1;
      end else begin
        cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
        tick  <= (cnt == LAST);
        if (tick) colon <= ~colon;
      end
    end
  end

  assign min_tens = min_q[6:4];
  assign min_ones = min_q[3:0];
  assign sec_tens = sec_q[6:4];
  assign sec_ones = sec_q[3:0];

`ifdef DIGITALCLOCK_12H_EN
  // Display regs load from the next-state hours so 12 h output has no extra latency.
  function automatic logic [5:0] map12(input logic [5:0] h);
    logic [4:0] b;
    logic [4:0] d;
    b = 5'(h[5:4]) * 5'd10 + 5'(h[3:0]);
    if (b == 5'd0)       d = 5'd12;
    else if (b > 5'd12)  d = b - 5'd12;
    else                 d = b;
    if (d >= 5'd10) return {2'd1, 4'(d - 5'd10)};
    else            return {2'd0, d[3:0]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hr_tens <= 2'd1;
      hr_ones <= 4'd2;
      pm      <= 1'b0;
    end else begin
      {hr_tens, hr_ones} <= map12(hr_n);
      pm                 <= (hr_n >= 6'h12);
    end
  end
`else
  assign hr_tens = hr_q[5:4];
  assign hr_ones = hr_q[3:0];
`endif

endmodule

// File: tb/tb_digitalclock_timekeeper.sv
// Directed bench for digitalclock_timekeeper with TICK_DIV=4; expected times are hand-derived.
module tb_digitalclock_timekeeper;

  logic       clk;
  logic       rst;
  logic       set_hours;
  logic       set_minutes;
  logic       inc;
  logic [1:0] hr_tens;
  logic [3:0] hr_ones;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       colon;
  logic       tick;
`ifdef DIGITALCLOCK_12H_EN
  logic       pm;
`endif

  int errors;
  int checks;
  int tick_set_cnt;
  logic count_ticks;

  digitalclock_timekeeper #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .set_hours   (set_hours),
    .set_minutes (set_minutes),
    .inc         (inc),
    .hr_tens     (hr_tens),
    .hr_ones     (hr_ones),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .colon       (colon),
    .tick        (tick)
`ifdef DIGITALCLOCK_12H_EN
    ,
    .pm          (pm)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (count_ticks && tick) tick_set_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    inc = 1'b1;
    step(1);
    inc = 1'b0;
    step(3);
  endtask

  function automatic logic [31:0] shown();
    return {8'h00, 2'b00, hr_tens, hr_ones, 1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};
  endfunction

  // Expected display as BCD hex from internal 24 h time.
  function automatic logic [31:0] exp_t(input int h, input int m, input int s);
    int hd;
    hd = h;
`ifdef DIGITALCLOCK_12H_EN
    if (h == 0) hd = 12;
    else if (h > 12) hd = h - 12;
`endif
    return 32'((hd / 10) << 20 | (hd % 10) << 16 | (m / 10) << 12 | (m % 10) << 8 |
               (s / 10) << 4 | (s % 10));
  endfunction

  task automatic check_pm(input string tag, input logic exp);
`ifdef DIGITALCLOCK_12H_EN
    check(tag, 32'(pm), 32'(exp));
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    tick_set_cnt = 0;
    count_ticks = 1'b0;
    rst = 1'b0;
    set_hours = 1'b0;
    set_minutes = 1'b0;
    inc = 1'b0;

    #12;
    check("reset_time", shown(), exp_t(0, 0, 0));
    check("reset_colon", 32'(colon), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check_pm("reset_pm", 1'b0);

    @(posedge clk);
    #1 rst = 1'b1;
    step(240);
    check("tick_60", 32'(tick), 32'd1);
    check("run_59s", shown(), exp_t(0, 0, 59));
    step(1);
    check("run_1min", shown(), exp_t(0, 1, 0));
    check("run_colon", 32'(colon), 32'd0);
    check("tick_width", 32'(tick), 32'd0);
    step(6);
    check("run_1min1s", shown(), exp_t(0, 1, 1));

    #2 rst = 1'b0;
    #1;
    check("async_rst_time", shown(), exp_t(0, 0, 0));
    check("async_rst_colon", 32'(colon), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    set_hours = 1'b1;
    step(1);
    check("set_colon", 32'(colon), 32'd1);

    repeat (5) press();
    check("set_h_5", shown(), exp_t(5, 0, 0));

    inc = 1'b1;
    step(2);
    check("hold_lat2", shown(), exp_t(5, 0, 0));
    step(1);
    check("hold_lat3", shown(), exp_t(6, 0, 0));
    step(47);
    check("hold_50", shown(), exp_t(6, 0, 0));
    inc = 1'b0;
    step(3);
    check("hold_release", shown(), exp_t(6, 0, 0));

    set_minutes = 1'b1;
    press();
    check("both_modes", shown(), exp_t(7, 0, 0));

    set_hours = 1'b0;
    set_minutes = 1'b0;
    press();
    check("run_ignore", shown(), exp_t(7, 0, 0));

    set_hours = 1'b1;
    repeat (6) press();
    check("set_h_13", shown(), exp_t(13, 0, 0));
    check_pm("pm_13", 1'b1);
    repeat (10) press();
    check("set_h_23", shown(), exp_t(23, 0, 0));
    check_pm("pm_23", 1'b1);
    press();
    check("set_h_wrap", shown(), exp_t(0, 0, 0));
    check_pm("pm_wrap", 1'b0);
    repeat (23) press();
    check("set_h_23b", shown(), exp_t(23, 0, 0));

    set_hours = 1'b0;
    set_minutes = 1'b1;
    step(1);
    count_ticks = 1'b1;
    repeat (58) press();
    check("set_m_58", shown(), exp_t(23, 58, 0));
    press();
    check("set_m_59", shown(), exp_t(23, 59, 0));
    press();
    check("set_m_wrap", shown(), exp_t(23, 0, 0));
    repeat (59) press();
    check("set_m_59b", shown(), exp_t(23, 59, 0));
    count_ticks = 1'b0;
    check("set_no_tick", 32'(tick_set_cnt), 32'd0);

    set_minutes = 1'b0;
    step(237);
    check("roll_235959", shown(), exp_t(23, 59, 59));
    check("roll_colon59", 32'(colon), 32'd0);
    step(3);
    check("roll_tick", 32'(tick), 32'd1);
    check("roll_hold", shown(), exp_t(23, 59, 59));
    step(1);
    check("roll_000000", shown(), exp_t(0, 0, 0));
    check("roll_hr_tens", 32'(hr_tens), exp_t(0, 0, 0) >> 20);
    check("roll_colon60", 32'(colon), 32'd1);
    check_pm("roll_pm", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
